// File: rtl/pdp11_bus_pkg.sv
// PDP-11 external bus interface: shared types and defaults.
// Imported by the bus interface and anything that talks to it.
package pdp11_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int DEF_WAIT_CYCLES = 1;
  localparam logic [ADDR_W-1:0] DEF_IO_BASE = 16'hFE00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_TURN,
    S_RD,
    S_RREC,
    S_WR,
    S_WHOLD,
    S_ERR
  } state_t;

endpackage

// File: rtl/pdp11_bus_if.sv
// PDP-11 multiplexed address/data pad bus master.
// Single outstanding request; RAM byte writes run as read-modify-write.
module pdp11_bus_if
  import pdp11_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [ADDR_W-1:0] IO_BASE = DEF_IO_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] bus_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic              latch_enable,
  output logic              bus_dir,
  output logic              oe_n,
  output logic              we_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_t state, state_d;

  logic [CW-1:0]     cnt;
  logic              we_q;
  logic              byte_q;
  logic              io_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_q;

  logic       accept;
  logic       direct_wr;
  logic       cnt_done;
  logic       strobe_entry;
  logic [7:0] rd_byte;

  assign accept    = req_valid && req_ready
                   && (state == S_IDLE);
  assign direct_wr = we_q && (!byte_q || io_q);
  assign cnt_done  = (cnt == '0);
  assign rd_byte   = addr_q[0] ? bus_in[15:8]
                               : bus_in[7:0];

  assign strobe_entry = (state_d != state)
    && (state_d == S_RD || state_d == S_WR);

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_d = (!req_byte && req_addr[0])
                  ? S_ERR : S_ADDR;
      S_ERR:   state_d = S_IDLE;
      S_ADDR:  state_d = S_LATCH;
      S_LATCH: state_d = direct_wr ? S_WR : S_TURN;
      S_TURN:  state_d = S_RD;
      S_RD:    if (cnt_done) state_d = S_RREC;
      S_RREC:  state_d = we_q ? S_WR : S_IDLE;
      S_WR:    if (cnt_done) state_d = S_WHOLD;
      S_WHOLD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      byte_q <= 1'b0;
      io_q   <= 1'b0;
      addr_q <= '0;
      wr_q   <= '0;
    end else begin
      state <= state_d;
      if (strobe_entry)
        cnt <= CNT_LOAD;
      else if (!cnt_done)
        cnt <= cnt - CW'(1);
      if (accept) begin
        we_q   <= req_we;
        byte_q <= req_byte;
        io_q   <= (req_addr >= IO_BASE);
        addr_q <= req_addr;
        wr_q   <= req_byte
                ? {req_wdata[7:0], req_wdata[7:0]}
                : req_wdata;
      end
      // RMW: splice the new byte into the word just read back
      if (state == S_RREC && we_q)
        wr_q <= addr_q[0]
              ? {wr_q[7:0], bus_in[7:0]}
              : {bus_in[15:8], wr_q[7:0]};
    end
  end

  // Pads and response are a registered decode of the current state,
  // so every output lags the state register by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      bus_out      <= '0;
      latch_enable <= 1'b0;
      bus_dir      <= 1'b0;
      oe_n         <= 1'b1;
      we_n         <= 1'b1;
    end else begin
      req_ready    <= (state == S_IDLE);
      rsp_valid    <= (state == S_ERR)
                   || (state == S_WHOLD)
                   || (state == S_RREC && !we_q);
      rsp_err      <= (state == S_ERR);
      latch_enable <= (state == S_ADDR);
      bus_dir      <= state inside {S_TURN, S_RD, S_RREC};
      oe_n         <= (state != S_RD);
      we_n         <= (state != S_WR);
      if (state == S_RREC && !we_q)
        rsp_rdata <= byte_q ? {8'h00, rd_byte} : bus_in;
      unique case (1'b1)
        (state == S_ADDR),
        (state == S_LATCH): bus_out <= addr_q;
        (state == S_WR),
        (state == S_WHOLD): bus_out <= wr_q;
        (state == S_IDLE),
        (state == S_ERR):   bus_out <= '0;
        default:            bus_out <= bus_out;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp11_bus_if.sv
// Scoreboard bench for pdp11_bus_if: directed requests, expected
// responses and pad writes queued, checked by a negedge monitor.
module tb_pdp11_bus_if;

  localparam int W = 2;
  localparam int P = 10;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] bus_out;
  logic [15:0] bus_in;
  logic        latch_enable;
  logic        bus_dir;
  logic        oe_n;
  logic        we_n;
  logic [15:0] ext_word;

  pdp11_bus_if #(.WAIT_CYCLES(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_byte(req_byte),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .bus_out(bus_out),
    .bus_in(bus_in),
    .latch_enable(latch_enable),
    .bus_dir(bus_dir),
    .oe_n(oe_n),
    .we_n(we_n)
  );

  // external memory only drives the pads when the block releases them
  assign bus_in = bus_dir ? ext_word : 16'hDEAD;

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  typedef struct {
    logic        we;
    logic        byt;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] ext;
    logic        err;
    logic        rchk;
    logic [15:0] rd;
    int          lat;
    int          oe;
    logic        wchk;
    logic [15:0] wexp;
  } vec_t;

  typedef struct {
    vec_t v;
    time  acc_t;
  } exp_t;

  exp_t        q[$];
  logic [15:0] wq[$];
  vec_t        vecs[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  // monitor
  int          le_cnt, oe_cnt, we_cnt, we_low;
  logic        le_p, oe_p, we_p, dir_p;
  logic [15:0] le_addr;

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] wx;
    if (!rst_n) begin
      le_cnt = 0; oe_cnt = 0; we_cnt = 0; we_low = 0;
      le_p = 0; oe_p = 1; we_p = 1; dir_p = 0;
    end else begin
      if (latch_enable && !le_p) begin
        le_cnt++;
        le_addr = bus_out;
      end
      if (!oe_n && oe_p) oe_cnt++;
      if (!we_n && we_p) we_cnt++;
      if (!we_n) we_low++;
      if (bus_dir && !dir_p)
        chk("dir_rise_le", {31'd0, latch_enable}, 32'd0);
      if (!bus_dir && dir_p)
        chk("dir_fall_oe", {31'd0, oe_n}, 32'd1);
      if (we_n && !we_p) begin
        chk("we_low_clks", we_low, W);
        chk("write_dir", {31'd0, bus_dir}, 32'd0);
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %0h want none",
                   bus_out);
        end else begin
          wx = wq.pop_front();
          chk("write_data", {16'd0, bus_out}, {16'd0, wx});
        end
        we_low = 0;
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got err=%0d want none",
                   rsp_err);
        end else begin
          e = q.pop_front();
          chk("latency", int'(($time - e.acc_t) / P), e.v.lat);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.v.err});
          if (e.v.rchk)
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.v.rd});
          chk("le_pulses", le_cnt, e.v.err ? 0 : 1);
          if (!e.v.err)
            chk("latched_addr", {16'd0, le_addr}, {16'd0, e.v.a});
          chk("oe_pulses", oe_cnt, e.v.oe);
          chk("we_pulses", we_cnt, e.v.wchk ? 1 : 0);
        end
        le_cnt = 0; oe_cnt = 0; we_cnt = 0;
      end
      le_p = latch_enable; oe_p = oe_n;
      we_p = we_n; dir_p = bus_dir;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
  endtask

  task automatic drive(input vec_t v);
    ext_word  = v.ext;
    req_we    = v.we;
    req_byte  = v.byt;
    req_addr  = v.a;
    req_wdata = v.wd;
    req_valid = 1'b1;
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   n = 0;
    wait_ready();
    drive(v);
    @(posedge clk);
    e.v = v;
    e.acc_t = $time;
    q.push_back(e);
    if (v.wchk) wq.push_back(v.wexp);
    #1 req_valid = 1'b0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got none want rsp @%0h", v.a);
      q.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] RST_OUT = {1'b1, 1'b0, 1'b0,
    16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0};

  function automatic logic [31:0] outs();
    return {req_ready, rsp_valid, rsp_err, bus_out,
            latch_enable, bus_dir, oe_n, we_n, 9'd0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   n;
    req_valid = 0; req_we = 0; req_byte = 0;
    req_addr = 0; req_wdata = 0; ext_word = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), RST_OUT);
    chk("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    //              we byt addr     wdata    ext      err rchk rdata   lat      oe wchk wexp
    vecs.push_back('{0, 0, 16'h0004, 16'h0000, 16'h0174, 0, 1, 16'h0174, 4+W,   1, 0, 16'h0000});
    vecs.push_back('{1, 0, 16'h000C, 16'hAB1B, 16'h0000, 0, 0, 16'h0000, 3+W,   0, 1, 16'hAB1B});
    vecs.push_back('{1, 1, 16'h0003, 16'hEE20, 16'h6360, 0, 0, 16'h0000, 5+2*W, 1, 1, 16'h2060});
    vecs.push_back('{1, 1, 16'hFE00, 16'hFF41, 16'h0000, 0, 0, 16'h0000, 3+W,   0, 1, 16'h4141});
    vecs.push_back('{0, 0, 16'h0005, 16'h0000, 16'h1234, 1, 0, 16'h0000, 1,     0, 0, 16'h0000});
    vecs.push_back('{0, 1, 16'h0003, 16'h0000, 16'h6360, 0, 1, 16'h0063, 4+W,   1, 0, 16'h0000});
    vecs.push_back('{0, 1, 16'h0002, 16'h0000, 16'h6360, 0, 1, 16'h0060, 4+W,   1, 0, 16'h0000});
    vecs.push_back('{1, 1, 16'h0002, 16'h00A5, 16'h1234, 0, 0, 16'h0000, 5+2*W, 1, 1, 16'h12A5});
    vecs.push_back('{1, 0, 16'h0007, 16'h5555, 16'h0000, 1, 0, 16'h0000, 1,     0, 0, 16'h0000});
    vecs.push_back('{1, 1, 16'hFFFF, 16'h0077, 16'h0000, 0, 0, 16'h0000, 3+W,   0, 1, 16'h7777});
    vecs.push_back('{1, 1, 16'hFDFF, 16'h005A, 16'h1111, 0, 0, 16'h0000, 5+2*W, 1, 1, 16'h5A11});
    vecs.push_back('{0, 1, 16'h0005, 16'h0000, 16'hBEEF, 0, 1, 16'h00BE, 4+W,   1, 0, 16'h0000});

    foreach (vecs[i]) run(vecs[i]);

    // reset in the middle of a read strobe
    rv = vecs[0];
    wait_ready();
    drive(rv);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (oe_n && n < 20) begin
      @(negedge clk); n++;
    end
    if (oe_n) begin
      checks++; errors++;
      $display("FAIL oe_timeout: got 1 want 0");
    end
    #2 rst_n = 1'b0;
    #1 chk("midrd_reset_outs", outs(), RST_OUT);
    chk("midrd_reset_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
    chk("post_reset_oe", {31'd0, oe_n}, 32'd1);

    rv = vecs[6];
    run(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
